frog_hop_ctrl: RTL

- Grid-hop motion controller for the player sprite; replaces free-running bounce motion with discrete, animated hops.
- Driven once per video frame from the USB keycode. Feeds position and size to the colour mapper, and status to LEDG.
- Adds press edge-detection, multi-frame hop animation, a one-deep hop buffer, bounds rejection, respawn, and a forward-hop score.

---
 rtl/frog_hop_ctrl_if.sv | 22 ++
 rtl/frog_hop_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/frog_hop_ctrl_if.sv
// Keycode/respawn inputs and sprite position/status outputs of the frog hop controller.
interface frog_hop_ctrl_if;
    logic [15:0] keycode;
    logic        respawn;
    logic [9:0]  FrogX;
    logic [9:0]  FrogY;
    logic [9:0]  FrogS;
    logic [1:0]  facing;
    logic        hopping;
    logic [7:0]  score;
    logic [8:0]  LEDG;

    modport master (
        output keycode, respawn,
        input  FrogX, FrogY, FrogS, facing, hopping, score, LEDG
    );

    modport slave (
        input  keycode, respawn,
        output FrogX, FrogY, FrogS, facing, hopping, score, LEDG
    );
endinterface

// File: rtl/frog_hop_ctrl.sv
// Per-frame grid-hop controller: edge-detected key presses start multi-frame hops,
// with a one-deep hop buffer, bounds rejection, respawn and a forward-hop score.
module frog_hop_ctrl #(
    parameter int unsigned X_START    = 320,
    parameter int unsigned Y_START    = 464,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX      = 479,
    parameter int unsigned FROG_SIZE  = 8,
    parameter int unsigned HOP_DIST   = 16,
    parameter int unsigned HOP_FRAMES = 4,
    parameter logic [15:0] KEY_UP     = 16'h001A,
    parameter logic [15:0] KEY_LEFT   = 16'h0004,
    parameter logic [15:0] KEY_RIGHT  = 16'h0007,
    parameter logic [15:0] KEY_DOWN   = 16'h0016
) (
    input  logic           frame_clk,
    input  logic           Reset,
    frog_hop_ctrl_if.slave bus
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LIM_W = POS_W + 1;

    localparam logic [POS_W-1:0] STEP     = POS_W'(HOP_DIST / HOP_FRAMES);
    localparam logic [LIM_W-1:0] HOP_D    = LIM_W'(HOP_DIST);
    localparam logic [LIM_W-1:0] UP_LIM   = LIM_W'(Y_MIN + FROG_SIZE + HOP_DIST);
    localparam logic [LIM_W-1:0] DOWN_LIM = LIM_W'(Y_MAX - FROG_SIZE);
    localparam logic [LIM_W-1:0] LEFT_LIM = LIM_W'(X_MIN + FROG_SIZE + HOP_DIST);
    localparam logic [LIM_W-1:0] RGHT_LIM = LIM_W'(X_MAX - FROG_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOP_FRAMES - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic {S_IDLE, S_HOP} state_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]       facing_q, facing_d, dir_q, dir_d, pend_dir_q, pend_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_vld_q, pend_vld_d, blocked_q, blocked_d;
    logic [15:0]      key_prev_q, key_prev_d;
    logic [7:0]       score_q, score_d;
    logic [8:0]       ledg_q, ledg_d;

    logic             key_hit_c, press_c, req_vld_c;
    logic [1:0]       key_dir_c, req_dir_c;
    logic [3:0]       legal_c;

    // Keycode decode and press edge detection
    always_comb begin
        key_hit_c = 1'b1;
        key_dir_c = DIR_UP;
        unique case (bus.keycode)
            KEY_UP:    key_dir_c = DIR_UP;
            KEY_LEFT:  key_dir_c = DIR_LEFT;
            KEY_RIGHT: key_dir_c = DIR_RIGHT;
            KEY_DOWN:  key_dir_c = DIR_DOWN;
            default:   key_hit_c = 1'b0;
        endcase
        press_c = key_hit_c && (bus.keycode != key_prev_q);
    end

    // Target-in-bounds test for each direction from the current position
    always_comb begin
        legal_c[DIR_UP]    = {1'b0, y_q} >= UP_LIM;
        legal_c[DIR_LEFT]  = {1'b0, x_q} >= LEFT_LIM;
        legal_c[DIR_RIGHT] = ({1'b0, x_q} + HOP_D) <= RGHT_LIM;
        legal_c[DIR_DOWN]  = ({1'b0, y_q} + HOP_D) <= DOWN_LIM;
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        facing_d   = facing_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        score_d    = score_q;
        blocked_d  = 1'b0;
        key_prev_d = bus.keycode;
        req_vld_c  = 1'b0;
        req_dir_c  = DIR_UP;
        // Status LEDs show the state held during the previous frame
        ledg_d     = {2'b00, blocked_q, pend_vld_q, state_q == S_HOP, 4'b0001 << facing_q};

        unique case (state_q)
            S_IDLE: begin
                // A buffered hop wins over a fresh press, which is then dropped
                if (pend_vld_q) begin
                    req_vld_c  = 1'b1;
                    req_dir_c  = pend_dir_q;
                    pend_vld_d = 1'b0;
                end else if (press_c) begin
                    req_vld_c = 1'b1;
                    req_dir_c = key_dir_c;
                end
                if (req_vld_c) begin
                    facing_d = req_dir_c;
                    if (legal_c[req_dir_c]) begin
                        dir_d   = req_dir_c;
                        cnt_d   = '0;
                        state_d = S_HOP;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            S_HOP: begin
                unique case (dir_q)
                    DIR_UP:    y_d = y_q - STEP;
                    DIR_LEFT:  x_d = x_q - STEP;
                    DIR_RIGHT: x_d = x_q + STEP;
                    DIR_DOWN:  y_d = y_q + STEP;
                endcase
                cnt_d = cnt_q + CNT_W'(1);
                if (press_c) begin
                    pend_vld_d = 1'b1;
                    pend_dir_d = key_dir_c;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    if (dir_q == DIR_UP && score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Respawn aborts any hop and discards the buffer but keeps the score
        if (bus.respawn) begin
            x_d        = POS_W'(X_START);
            y_d        = POS_W'(Y_START);
            state_d    = S_IDLE;
            cnt_d      = '0;
            pend_vld_d = 1'b0;
            facing_d   = DIR_UP;
            blocked_d  = 1'b0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            x_q        <= POS_W'(X_START);
            y_q        <= POS_W'(Y_START);
            facing_q   <= DIR_UP;
            dir_q      <= DIR_UP;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= DIR_UP;
            blocked_q  <= 1'b0;
            key_prev_q <= '0;
            score_q    <= '0;
            ledg_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            facing_q   <= facing_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            blocked_q  <= blocked_d;
            key_prev_q <= key_prev_d;
            score_q    <= score_d;
            ledg_q     <= ledg_d;
        end
    end

    assign bus.FrogX   = x_q;
    assign bus.FrogY   = y_q;
    assign bus.FrogS   = POS_W'(FROG_SIZE);
    assign bus.facing  = facing_q;
    assign bus.hopping = (state_q == S_HOP);
    assign bus.score   = score_q;
    assign bus.LEDG    = ledg_q;

endmodule
